i2s_transmitter: RTL and testbench
==================================

I2S_TRANSMITTER -- requirements
Module: i2s_transmitter

Interface
REQ-001 SHALL have parameter SCLK_DIV, default 16, meaning clk_in cycles per sclk half-period; legal range is 2 or more.
REQ-002 SHALL have port clk_in, input, 1 bit, system clock (100 MHz).
REQ-003 SHALL have port rst_in, input, 1 bit; it is the only reset, asynchronous and active-low.
REQ-004 SHALL have port left_in, input, 16 bits, signed left sample.
REQ-005 SHALL have port right_in, input, 16 bits, signed right sample.
REQ-006 SHALL have port valid_in, input, 1 bit, sample pair offered.
REQ-007 SHALL have port ready_out, output, 1 bit, holding register empty.
REQ-008 SHALL have port sclk_out, output, 1 bit, I2S bit clock.
REQ-009 SHALL have port ws_out, output, 1 bit, I2S word select (0 = left, 1 = right).
REQ-010 SHALL have port sdata_out, output, 1 bit, I2S serial data.
REQ-011 SHALL have port frame_out, output, 1 bit, one-cycle pulse on every frame latch.
REQ-012 SHALL have port underrun_out, output, 1 bit, one-cycle pulse when a latch finds the holding register empty.

Function
REQ-013 SHALL count clk_in cycles 0..SCLK_DIV-1 and toggle sclk_out on the terminal count, giving an sclk period of 2*SCLK_DIV cycles.
REQ-014 SHALL treat a terminal count while sclk_out=1 as a falling-edge event, and SHALL update slot counter s (0..63, wraps 63->0), ws_out and sdata_out only on that clock cycle.
REQ-015 SHALL drive ws_out=1 for s in 31..62 and ws_out=0 for s=63 and s in 0..30, so ws_out leads each channel MSB by one sclk.
REQ-016 SHALL drive sdata_out as follows, MSB first: for s=0..15, left[15-s]; for s=16..31, 0; for s=32..47, right[47-s]; for s=48..63, 0.
REQ-017 SHALL accept a sample pair into the holding register on any cycle where valid_in and ready_out are both 1.
REQ-018 SHALL drive ready_out as the inverse of the holding-register full flag.
REQ-019 SHALL perform a frame latch on the falling-edge event that moves s from 63 to 0: load the shift pair from the holding register, mark the holding register empty, and pulse frame_out on that cycle.
REQ-020 SHALL make the latched MSB (left[15]) visible on sdata_out in the same cycle as the frame latch.
REQ-021 SHALL, when a handshake and a frame latch occur in the same cycle, latch the old holding contents and leave the new pair in the holding register, full.
REQ-022 SHALL, when the holding register is empty at a frame latch, pulse underrun_out and load the shift pair per REQ-027.
REQ-023 SHALL ignore valid_in while ready_out=0 and SHALL never overwrite a full holding register.

Reset
REQ-024 SHALL, while rst_in=0, force: sclk_out=0, ws_out=0, sdata_out=0, frame_out=0, underrun_out=0, divider=0, s=63, holding register empty (ready_out=1), and shift pair and last pair = 0.
REQ-025 SHALL abort any frame in progress on reset assertion; after release, the first falling-edge event (2*SCLK_DIV cycles after release) performs a frame latch.

Configuration
REQ-026 SHALL, when I2S_TX_UNDERRUN_ZERO_EN is defined, load 0 into both channels on an underrun latch.
REQ-027 SHALL, when I2S_TX_UNDERRUN_ZERO_EN is undefined, reload the last successfully latched pair on an underrun latch; the last pair is 0 after reset.

Verification
REQ-028 SHALL cover: SCLK_DIV=16, left=16'hA5C3, right=16'h1234 offered before the first frame -> at the first frame latch frame_out pulses, and sclk-sampled sdata_out yields A5C3, 16 zeros, 1234, 16 zeros.
REQ-029 SHALL cover: the same setup -> sclk period is 32 cycles, ws_out rises at s=31 and falls at s=63, and a frame latch occurs every 2048 cycles.
REQ-030 SHALL cover: valid_in held high continuously -> ready_out=0 after acceptance, and exactly one pair is accepted per frame with no pair lost or duplicated.
REQ-031 SHALL cover: no data offered after one frame of 16'h7FFF/16'h8000 -> underrun_out pulses at the next latch; that frame carries 7FFF/8000 without the macro, or all zeros with I2S_TX_UNDERRUN_ZERO_EN.
REQ-032 SHALL cover: valid_in asserted on the exact latch cycle with pair 16'h0001/16'h0002 -> old pair transmitted, ready_out=0, and 0001/0002 transmitted in the following frame.
REQ-033 SHALL cover: rst_in pulsed low mid-frame at s=20 -> outputs immediately return to reset values, and the first post-release latch occurs after 2*SCLK_DIV cycles.

Source files
------------

// File: rtl/i2s_transmitter.sv
// I2S transmitter: 16-bit stereo, 64 sclk per frame, with a one-pair holding register.
// Optional build macro I2S_TX_UNDERRUN_ZERO_EN sends silence on underrun instead of repeating the last pair.
module i2s_transmitter #(
  parameter int SCLK_DIV = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [15:0] left_in,
  input  logic [15:0] right_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic        sclk_out,
  output logic        ws_out,
  output logic        sdata_out,
  output logic        frame_out,
  output logic        underrun_out
);

  localparam int DIV_W = (SCLK_DIV > 2) ? $clog2(SCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);

  logic [DIV_W-1:0] div_reg, div_next;
  logic             sclk_reg, sclk_next;
  logic [5:0]       s_reg, s_next;
  logic             ws_reg, ws_next;
  logic             sdata_reg, sdata_next;
  logic             frame_reg, frame_next;
  logic             underrun_reg, underrun_next;
  logic             hold_full_reg, hold_full_next;
  logic [15:0]      hold_l_reg, hold_l_next, hold_r_reg, hold_r_next;
  logic [15:0]      sh_l_reg, sh_l_next, sh_r_reg, sh_r_next;
  logic [15:0]      last_l_reg, last_l_next, last_r_reg, last_r_next;

  logic terminal, fall, latch, accept;
  logic [3:0] bit_idx;

  always_comb begin
    div_next       = div_reg;
    sclk_next      = sclk_reg;
    s_next         = s_reg;
    ws_next        = ws_reg;
    sdata_next     = sdata_reg;
    frame_next     = 1'b0;
    underrun_next  = 1'b0;
    hold_full_next = hold_full_reg;
    hold_l_next    = hold_l_reg;
    hold_r_next    = hold_r_reg;
    sh_l_next      = sh_l_reg;
    sh_r_next      = sh_r_reg;
    last_l_next    = last_l_reg;
    last_r_next    = last_r_reg;
    bit_idx        = 4'd0;

    terminal = (div_reg == DIV_LAST);
    fall     = terminal && sclk_reg;
    latch    = fall && (s_reg == 6'd63);
    accept   = valid_in && !hold_full_reg;

    div_next = terminal ? '0 : div_reg + DIV_W'(1);
    if (terminal) sclk_next = ~sclk_reg;

    if (accept) begin
      hold_l_next    = left_in;
      hold_r_next    = right_in;
      hold_full_next = 1'b1;
    end

    // A handshake can only land while the holding register is empty, so on a
    // latch the register ends up full exactly when a new pair arrives this cycle.
    if (latch) begin
      frame_next     = 1'b1;
      hold_full_next = accept;
      if (hold_full_reg) begin
        sh_l_next   = hold_l_reg;
        sh_r_next   = hold_r_reg;
        last_l_next = hold_l_reg;
        last_r_next = hold_r_reg;
      end else begin
        underrun_next = 1'b1;
`ifdef I2S_TX_UNDERRUN_ZERO_EN
        sh_l_next = 16'd0;
        sh_r_next = 16'd0;
`else
        sh_l_next = last_l_reg;
        sh_r_next = last_r_reg;
`endif
      end
    end

    // Slot s carries bit 15-(s mod 16) of its channel in the first half of each word.
    if (fall) begin
      s_next  = s_reg + 6'd1;
      ws_next = (s_next >= 6'd31) && (s_next <= 6'd62);
      bit_idx = ~s_next[3:0];
      if (s_next[4])      sdata_next = 1'b0;
      else if (s_next[5]) sdata_next = sh_r_next[bit_idx];
      else                sdata_next = sh_l_next[bit_idx];
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      div_reg       <= '0;
      sclk_reg      <= 1'b0;
      s_reg         <= 6'd63;
      ws_reg        <= 1'b0;
      sdata_reg     <= 1'b0;
      frame_reg     <= 1'b0;
      underrun_reg  <= 1'b0;
      hold_full_reg <= 1'b0;
      hold_l_reg    <= 16'd0;
      hold_r_reg    <= 16'd0;
      sh_l_reg      <= 16'd0;
      sh_r_reg      <= 16'd0;
      last_l_reg    <= 16'd0;
      last_r_reg    <= 16'd0;
    end else begin
      div_reg       <= div_next;
      sclk_reg      <= sclk_next;
      s_reg         <= s_next;
      ws_reg        <= ws_next;
      sdata_reg     <= sdata_next;
      frame_reg     <= frame_next;
      underrun_reg  <= underrun_next;
      hold_full_reg <= hold_full_next;
      hold_l_reg    <= hold_l_next;
      hold_r_reg    <= hold_r_next;
      sh_l_reg      <= sh_l_next;
      sh_r_reg      <= sh_r_next;
      last_l_reg    <= last_l_next;
      last_r_reg    <= last_r_next;
    end
  end

  assign ready_out    = ~hold_full_reg;
  assign sclk_out     = sclk_reg;
  assign ws_out       = ws_reg;
  assign sdata_out    = sdata_reg;
  assign frame_out    = frame_reg;
  assign underrun_out = underrun_reg;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed bench for i2s_transmitter: frame format, handshake, underrun and reset behaviour.
// Expectations follow the I2S_TX_UNDERRUN_ZERO_EN build macro when it is defined.
module tb_i2s_transmitter;

  localparam int SCLK_DIV = 16;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [15:0] left_in = 16'd0;
  logic [15:0] right_in = 16'd0;
  logic        valid_in = 1'b0;
  logic        ready_out, sclk_out, ws_out, sdata_out, frame_out, underrun_out;

  i2s_transmitter #(.SCLK_DIV(SCLK_DIV)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .left_in(left_in), .right_in(right_in),
    .valid_in(valid_in), .ready_out(ready_out), .sclk_out(sclk_out), .ws_out(ws_out),
    .sdata_out(sdata_out), .frame_out(frame_out), .underrun_out(underrun_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_count = 0;
  int acc_seen = 0;
  int k = 0;
  int fcyc = 0;
  bit stream_on = 1'b0;

  localparam logic [63:0] WS_EXP = 64'h0000_0001_FFFF_FFFE;
`ifdef I2S_TX_UNDERRUN_ZERO_EN
  localparam logic [63:0] UR_EXP = 64'h0;
`else
  localparam logic [63:0] UR_EXP = 64'h7FFF_0000_8000_0000;
`endif

  always @(posedge clk_in) begin
    cyc <= cyc + 1;
    if (valid_in && ready_out) acc_count <= acc_count + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // One clock step; while streaming, offer a fresh pair after every accepted one.
  task automatic tick();
    @(negedge clk_in);
    if (stream_on && acc_count != acc_seen) begin
      acc_seen = acc_count;
      k++;
      left_in  = 16'h1000 + 16'(k);
      right_in = 16'h2000 + 16'(k);
    end
  endtask

  task automatic wait_frame(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!frame_out && n < 5000);
    if (!frame_out) check("frame_timeout", 64'(frame_out), 64'd1);
    fcyc = cyc;
  endtask

  task automatic capture(output logic [63:0] data, output logic [63:0] ws, output int period);
    int n;
    int first;
    logic prev;
    data = '0;
    ws = '0;
    period = 0;
    first = 0;
    for (int i = 0; i < 64; i++) begin
      n = 0;
      do begin
        prev = sclk_out;
        tick();
        n++;
      end while (!(sclk_out && !prev) && n < 100);
      if (n >= 100) begin
        check("sclk_timeout", 64'(sclk_out), 64'd1);
        return;
      end
      data[63-i] = sdata_out;
      ws[63-i]   = ws_out;
      if (i == 0) first = cyc;
      if (i == 1) period = cyc - first;
    end
  endtask

  initial begin
    int n;
    int f1;
    int per;
    logic [63:0] data, wsv;

    repeat (3) @(negedge clk_in);
    check("rst_sclk", 64'(sclk_out), 64'd0);
    check("rst_ws", 64'(ws_out), 64'd0);
    check("rst_sdata", 64'(sdata_out), 64'd0);
    check("rst_frame", 64'(frame_out), 64'd0);
    check("rst_underrun", 64'(underrun_out), 64'd0);
    check("rst_ready", 64'(ready_out), 64'd1);

    // Frame 1: A5C3 / 1234 offered right at release
    rst_in = 1'b1;
    valid_in = 1'b1; left_in = 16'hA5C3; right_in = 16'h1234;
    tick();
    valid_in = 1'b0;
    check("ready_after_accept", 64'(ready_out), 64'd0);
    wait_frame(n);
    check("first_latch_cycles", 64'(n + 1), 64'd32);
    check("f1_underrun", 64'(underrun_out), 64'd0);
    check("f1_msb_same_cycle", 64'(sdata_out), 64'd1);
    check("f1_ws_at_latch", 64'(ws_out), 64'd0);
    f1 = fcyc;
    capture(data, wsv, per);
    check("f1_data", data, 64'hA5C3_0000_1234_0000);
    check("f1_ws", wsv, WS_EXP);
    check("sclk_period", 64'(per), 64'd32);

    // Frame 2: 7FFF / 8000, then nothing offered
    valid_in = 1'b1; left_in = 16'h7FFF; right_in = 16'h8000;
    tick();
    valid_in = 1'b0;
    wait_frame(n);
    check("frame_period", 64'(fcyc - f1), 64'd2048);
    check("f2_underrun", 64'(underrun_out), 64'd0);
    capture(data, wsv, per);
    check("f2_data", data, 64'h7FFF_0000_8000_0000);

    // Frame 3: underrun
    wait_frame(n);
    check("f3_underrun", 64'(underrun_out), 64'd1);
    capture(data, wsv, per);
    check("f3_data", data, UR_EXP);

    // Frame 4: handshake on the exact latch cycle
    repeat (15) tick();
    valid_in = 1'b1; left_in = 16'h0001; right_in = 16'h0002;
    tick();
    check("f4_frame_on_latch", 64'(frame_out), 64'd1);
    check("f4_underrun", 64'(underrun_out), 64'd1);
    check("f4_ready_after", 64'(ready_out), 64'd0);
    valid_in = 1'b0;
    capture(data, wsv, per);
    check("f4_data_old", data, UR_EXP);
    wait_frame(n);
    check("f5_underrun", 64'(underrun_out), 64'd0);
    capture(data, wsv, per);
    check("f5_data", data, 64'h0001_0000_0002_0000);

    // Frames 6-7: valid held high with a new pair after each acceptance
    acc_seen = acc_count; k = 0;
    left_in = 16'h1000; right_in = 16'h2000;
    valid_in = 1'b1; stream_on = 1'b1;
    tick();
    check("stream_ready", 64'(ready_out), 64'd0);
    wait_frame(n);
    check("f6_underrun", 64'(underrun_out), 64'd0);
    capture(data, wsv, per);
    check("f6_data", data, 64'h1000_0000_2000_0000);
    wait_frame(n);
    check("f7_underrun", 64'(underrun_out), 64'd0);
    capture(data, wsv, per);
    check("f7_data", data, 64'h1001_0000_2001_0000);
    check("stream_accepts", 64'(k), 64'd3);
    stream_on = 1'b0; valid_in = 1'b0;

    // Frame 8 then reset at slot 20 with the holding register full
    wait_frame(n);
    check("f8_underrun", 64'(underrun_out), 64'd0);
    valid_in = 1'b1; left_in = 16'hBEEF; right_in = 16'hCAFE;
    tick();
    valid_in = 1'b0;
    check("f8_hold_full", 64'(ready_out), 64'd0);
    repeat (658) tick();
    check("pre_rst_sclk", 64'(sclk_out), 64'd1);
    rst_in = 1'b0;
    #1;
    check("mid_rst_sclk", 64'(sclk_out), 64'd0);
    check("mid_rst_ready", 64'(ready_out), 64'd1);
    check("mid_rst_ws", 64'(ws_out), 64'd0);
    check("mid_rst_sdata", 64'(sdata_out), 64'd0);
    tick();
    tick();
    rst_in = 1'b1;
    wait_frame(n);
    check("post_rst_latch_cycles", 64'(n), 64'd32);
    check("post_rst_underrun", 64'(underrun_out), 64'd1);
    capture(data, wsv, per);
    check("post_rst_data", data, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
